// File: rtl/bip_pkg.sv
// Shared definitions for the BIPI instruction sequencer: field widths,
// opcodes, ACC source selects, FSM state encoding and decoder payload.
package bip_pkg;

    localparam int unsigned PC_LENGTH       = 11;
    localparam int unsigned OPCODE_LENGTH   = 5;
    localparam int unsigned OPERANDO_LENGTH = 11;
    localparam int unsigned INSTR_LENGTH    = 16;
    localparam int unsigned SELA_LENGTH     = 2;
    localparam int unsigned CYCLE_CNT_W     = 32;

    localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPCODE_LENGTH-1:0] OP_STO  = 5'b00001;
    localparam logic [OPCODE_LENGTH-1:0] OP_LD   = 5'b00010;
    localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = 5'b00111;

    localparam logic [SELA_LENGTH-1:0] SELA_RAM = 2'b00;
    localparam logic [SELA_LENGTH-1:0] SELA_IMM = 2'b01;
    localparam logic [SELA_LENGTH-1:0] SELA_ALU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    typedef struct packed {
        logic [SELA_LENGTH-1:0] sel_a;
        logic                   sel_b;
        logic                   acc_we;
        logic                   ram_rd;
        logic                   ram_wr;
        logic                   is_halt;
    } dec_ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder; the sequencer gates these controls by state.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPCODE_LENGTH-1:0] i_opcode,
    output dec_ctrl_t                o_ctrl
);

    // Opcode to datapath/memory control; undefined opcodes decode as NOP.
    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_HLT: o_ctrl.is_halt = 1'b1;
            OP_STO: o_ctrl.ram_wr  = 1'b1;
            OP_LD: begin
                o_ctrl.ram_rd = 1'b1;
                o_ctrl.acc_we = 1'b1;
                o_ctrl.sel_a  = SELA_RAM;
            end
            OP_LDI: begin
                o_ctrl.acc_we = 1'b1;
                o_ctrl.sel_a  = SELA_IMM;
            end
            OP_ADD, OP_SUB: begin
                o_ctrl.ram_rd = 1'b1;
                o_ctrl.acc_we = 1'b1;
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.sel_b  = 1'b0;
            end
            OP_ADDI, OP_SUBI: begin
                o_ctrl.acc_we = 1'b1;
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.sel_b  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// BIPI instruction sequencer: FETCH/LOAD/EXEC/WB loop over a synchronous
// program ROM, driving datapath selects, ACC write and data-RAM strobes.
// Optional cycle counter enabled by defining BIP_CYCLE_COUNT_EN.
module bip_control
    import bip_pkg::*;
(
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [INSTR_LENGTH-1:0]    i_instruction,
    output logic [PC_LENGTH-1:0]       o_pc_addr,
    output logic [OPCODE_LENGTH-1:0]   o_opcode,
    output logic [OPERANDO_LENGTH-1:0] o_operando,
    output logic [SELA_LENGTH-1:0]     o_selA,
    output logic                       o_selB,
    output logic                       o_wrACC,
    output logic                       o_rdRAM,
    output logic                       o_wrRAM,
    output logic                       o_halt,
    output logic                       o_busy,
    output logic [CYCLE_CNT_W-1:0]     o_cycle_count
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PC_LENGTH-1:0]    r_pc;
    logic [PC_LENGTH-1:0]    w_pc_next;
    logic [INSTR_LENGTH-1:0] r_ir;
    logic [INSTR_LENGTH-1:0] w_ir_next;
    dec_ctrl_t               w_dec;

    bip_decoder u_decoder (
        .i_opcode (r_ir[INSTR_LENGTH-1 -: OPCODE_LENGTH]),
        .o_ctrl   (w_dec)
    );

    // IR fields are held from EXEC until the next LOAD overwrites the IR.
    assign o_pc_addr  = r_pc;
    assign o_opcode   = r_ir[INSTR_LENGTH-1 -: OPCODE_LENGTH];
    assign o_operando = r_ir[OPERANDO_LENGTH-1:0];

    // State, PC and IR registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
        end
    end

    // Next-state logic and state-gated control outputs.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        o_selA       = '0;
        o_selB       = 1'b0;
        o_wrACC      = 1'b0;
        o_rdRAM      = 1'b0;
        o_wrRAM      = 1'b0;
        o_halt       = 1'b0;
        o_busy       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_busy       = 1'b1;
                w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_busy       = 1'b1;
                w_ir_next    = i_instruction;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                o_busy  = 1'b1;
                o_selA  = w_dec.sel_a;
                o_selB  = w_dec.sel_b;
                o_rdRAM = w_dec.ram_rd;
                o_wrRAM = w_dec.ram_wr;
                // Halt is flagged as soon as HLT decodes; PC stays on the HLT.
                if (w_dec.is_halt) begin
                    o_halt       = 1'b1;
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_WB: begin
                o_busy       = 1'b1;
                o_selA       = w_dec.sel_a;
                o_selB       = w_dec.sel_b;
                o_wrACC      = w_dec.acc_we;
                w_pc_next    = r_pc + PC_LENGTH'(1);
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                o_halt = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A reset cycle aborts the current instruction before any strobe fires.
        if (i_reset) begin
            o_selA  = '0;
            o_selB  = 1'b0;
            o_wrACC = 1'b0;
            o_rdRAM = 1'b0;
            o_wrRAM = 1'b0;
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [CYCLE_CNT_W-1:0] r_cycle_count;

    // Busy-cycle counter: cleared on start, saturating, frozen when not busy.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cycle_count <= '0;
        end else if (r_state == ST_IDLE && w_state_next == ST_FETCH) begin
            r_cycle_count <= '0;
        end else if (o_busy && r_cycle_count != '1) begin
            r_cycle_count <= r_cycle_count + CYCLE_CNT_W'(1);
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Directed testbench for bip_control with a synchronous program ROM model.
module tb_bip_control;
    import bip_pkg::*;

    logic                       i_clock;
    logic                       i_reset;
    logic                       i_start;
    logic [INSTR_LENGTH-1:0]    i_instruction;
    logic [PC_LENGTH-1:0]       o_pc_addr;
    logic [OPCODE_LENGTH-1:0]   o_opcode;
    logic [OPERANDO_LENGTH-1:0] o_operando;
    logic [SELA_LENGTH-1:0]     o_selA;
    logic                       o_selB;
    logic                       o_wrACC;
    logic                       o_rdRAM;
    logic                       o_wrRAM;
    logic                       o_halt;
    logic                       o_busy;
    logic [CYCLE_CNT_W-1:0]     o_cycle_count;

    int n_checks;
    int n_errors;

    logic [INSTR_LENGTH-1:0] rom [0:2047];

`ifdef BIP_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    bip_control dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_instruction (i_instruction),
        .o_pc_addr     (o_pc_addr),
        .o_opcode      (o_opcode),
        .o_operando    (o_operando),
        .o_selA        (o_selA),
        .o_selB        (o_selB),
        .o_wrACC       (o_wrACC),
        .o_rdRAM       (o_rdRAM),
        .o_wrRAM       (o_wrRAM),
        .o_halt        (o_halt),
        .o_busy        (o_busy),
        .o_cycle_count (o_cycle_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Synchronous ROM: data valid the cycle after the address is presented.
    always @(posedge i_clock) i_instruction <= rom[o_pc_addr];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rom_fill(input logic [INSTR_LENGTH-1:0] v);
        for (int a = 0; a < 2048; a++) rom[a] = v;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        step(2);
        i_reset = 1'b0;
    endtask

    // Pulse start in IDLE; returns in the first FETCH cycle (cycle 1).
    task automatic start_pulse();
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    function automatic logic [31:0] ctl_vec();
        return 32'({o_selA, o_selB, o_wrACC, o_rdRAM, o_wrRAM, o_halt, o_busy});
    endfunction

    function automatic logic [31:0] cnt_exp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int strobe_hits;
        int seq_bad;
        logic [PC_LENGTH-1:0] pc_2047;
        logic [PC_LENGTH-1:0] pc_2048;
        n_checks = 0;
        n_errors = 0;
        i_reset  = 1'b1;
        i_start  = 1'b0;
        rom_fill('0);
        step(1);

        // Reset state
        do_reset();
        check("rst_pc", 32'(o_pc_addr), 32'd0);
        check("rst_ir", 32'({o_opcode, o_operando}), 32'd0);
        check("rst_ctl", ctl_vec(), 32'd0);
        check("rst_cnt", o_cycle_count, 32'd0);
        step(3);
        check("idle_wait", ctl_vec(), 32'd0);

        // LDI 5 then HLT
        rom[0] = 16'h1805;
        rom[1] = 16'h0000;
        start_pulse();
        check("ldi_fetch_pc", 32'(o_pc_addr), 32'd0);
        check("ldi_fetch_busy", 32'(o_busy), 32'd1);
        step(2);
        check("ldi_exec_op", 32'(o_opcode), 32'd3);
        check("ldi_exec_opnd", 32'(o_operando), 32'd5);
        check("ldi_exec_wracc", 32'(o_wrACC), 32'd0);
        step(1);
        check("ldi_wb_wracc", 32'(o_wrACC), 32'd1);
        check("ldi_wb_sela", 32'(o_selA), 32'd1);
        check("ldi_wb_opnd", 32'(o_operando), 32'd5);
        check("ldi_wb_rdram", 32'(o_rdRAM), 32'd0);
        step(1);
        check("ldi_next_pc", 32'(o_pc_addr), 32'd1);
        check("ldi_next_wracc", 32'(o_wrACC), 32'd0);
        step(2);
        check("hlt1_exec_halt", 32'(o_halt), 32'd1);
        step(1);
        check("hlt1_halt", 32'(o_halt), 32'd1);
        check("hlt1_busy", 32'(o_busy), 32'd0);
        check("hlt1_pc", 32'(o_pc_addr), 32'd1);
        check("hlt1_cnt", o_cycle_count, cnt_exp(7));
        step(3);
        check("hlt1_cnt_frozen", o_cycle_count, cnt_exp(7));

        // LD 7, ADDI 3, STO 2, HLT
        do_reset();
        rom_fill('0);
        rom[0] = 16'h1007;
        rom[1] = 16'h2803;
        rom[2] = 16'h0802;
        rom[3] = 16'h0000;
        start_pulse();
        step(2);
        check("ld_exec_op", 32'(o_opcode), 32'd2);
        check("ld_exec_rdram", 32'(o_rdRAM), 32'd1);
        check("ld_exec_wracc", 32'(o_wrACC), 32'd0);
        step(1);
        check("ld_wb_wracc", 32'(o_wrACC), 32'd1);
        check("ld_wb_sela", 32'(o_selA), 32'd0);
        check("ld_wb_rdram", 32'(o_rdRAM), 32'd0);
        step(1);
        check("addi_fetch_pc", 32'(o_pc_addr), 32'd1);
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        check("busy_start_ign", 32'({o_busy, o_pc_addr}), 32'({1'b1, 11'd1}));
        step(1);
        check("addi_exec_sel", 32'({o_selA, o_selB}), 32'b101);
        check("addi_exec_str", 32'({o_wrACC, o_rdRAM, o_wrRAM}), 32'd0);
        step(1);
        check("addi_wb", 32'({o_wrACC, o_selA, o_selB}), 32'b1101);
        step(3);
        check("sto_exec_wrram", 32'(o_wrRAM), 32'd1);
        check("sto_exec_opnd", 32'(o_operando), 32'd2);
        check("sto_exec_wracc", 32'(o_wrACC), 32'd0);
        step(1);
        check("sto_wb_str", 32'({o_wrACC, o_rdRAM, o_wrRAM}), 32'd0);
        step(3);
        check("hlt_c15_halt", 32'(o_halt), 32'd1);
        check("hlt_c15_pc", 32'(o_pc_addr), 32'd3);
        step(1);
        check("hlt_c16", 32'({o_halt, o_busy}), 32'b10);
        check("hlt_c16_pc", 32'(o_pc_addr), 32'd3);
        check("prog_cnt", o_cycle_count, cnt_exp(15));
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        step(1);
        check("halt_start_ign", 32'({o_halt, o_busy}), 32'b10);
        check("halt_start_pc", 32'(o_pc_addr), 32'd3);
        check("halt_start_cnt", o_cycle_count, cnt_exp(15));
        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0;
        check("halt_rst_pc", 32'(o_pc_addr), 32'd0);
        check("halt_rst_ctl", ctl_vec(), 32'd0);
        check("halt_rst_cnt", o_cycle_count, 32'd0);
        step(2);
        check("halt_rst_idle", 32'(o_busy), 32'd0);

        // Reset during EXEC of SUB 0
        rom_fill('0);
        rom[0] = 16'h3000;
        start_pulse();
        step(2);
        check("sub_exec_rdram", 32'(o_rdRAM), 32'd1);
        check("sub_exec_op", 32'(o_opcode), 32'd6);
        i_reset = 1'b1;
        #1;
        check("sub_rstcyc_str", 32'({o_wrACC, o_rdRAM, o_wrRAM}), 32'd0);
        step(1);
        i_reset = 1'b0;
        check("sub_rst_all", 32'({o_pc_addr, o_opcode, o_operando}), 32'd0);
        check("sub_rst_ctl", ctl_vec(), 32'd0);
        strobe_hits = 0;
        for (int c = 0; c < 5; c++) begin
            if (o_wrACC || o_rdRAM || o_wrRAM || o_busy) strobe_hits++;
            step(1);
        end
        check("sub_after_rst", 32'(strobe_hits), 32'd0);

        // 2048 NOPs: no strobes, PC wraps 2047 -> 0
        rom_fill(16'hF800);
        start_pulse();
        strobe_hits = 0;
        seq_bad     = 0;
        pc_2047     = '0;
        pc_2048     = '1;
        for (int k = 0; k < 2050; k++) begin
            if (o_pc_addr != PC_LENGTH'(k)) seq_bad++;
            if (k == 2047) pc_2047 = o_pc_addr;
            if (k == 2048) pc_2048 = o_pc_addr;
            for (int c = 0; c < 4; c++) begin
                if (o_wrACC || o_rdRAM || o_wrRAM || o_halt) strobe_hits++;
                if (!o_busy) seq_bad++;
                step(1);
            end
        end
        check("nop_strobes", 32'(strobe_hits), 32'd0);
        check("nop_seq", 32'(seq_bad), 32'd0);
        check("nop_pc_2047", 32'(pc_2047), 32'd2047);
        check("nop_pc_wrap", 32'(pc_2048), 32'd0);
        check("nop_pc_after", 32'(o_pc_addr), 32'd2);
        check("nop_opcode", 32'(o_opcode), 32'd31);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
